// File: rtl/spi_controller_pkg.sv
// spi_controller_pkg: shared state encoding and default sizing for the SPI master
package spi_controller_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;
endpackage

// File: rtl/spi_controller.sv
// spi_controller: mode-0 MSB-first SPI master shift engine
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_tx,
  output logic [WIDTH-1:0] data_rx,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, data_rx_q, data_rx_d;
  logic             busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic             div_last, load;
  assign div_last = div_q == DW'(DIV - 1);
  // a transfer may begin from IDLE or from the single DONE cycle, giving a 1-cycle busy gap
  assign load = start && (state_q == IDLE || state_q == DONE);
  // next-state and datapath: divider paces each sclk half-period, shifting on its edges
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = load ? LOW : IDLE;
        if (load) begin
          tx_d   = data_tx;
          mosi_d = data_tx[WIDTH-1];
          busy_d = 1'b1;
          div_d  = '0;
          cnt_d  = '0;
        end
      end
      LOW: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[WIDTH-2:0], miso};
          state_d = HIGH;
        end
      end
      HIGH: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          sclk_d = 1'b0;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d   = DONE;
            data_rx_d = rx_q;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            mosi_d    = 1'b0;
          end else begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[WIDTH-2];
            cnt_d   = cnt_q + 1'b1;
            state_d = LOW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset aborts any transfer without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end
  assign data_rx = data_rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for the SPI master (DIV=2 and DIV=1 instances)
module tb_spi_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, busy_a, done_a, sclk_a, mosi_a, miso_a;
  logic [7:0] data_a, data_rx_a;
  logic       start_b, busy_b, done_b, sclk_b, mosi_b;
  logic [7:0] data_b, data_rx_b;
  logic       use_slave;
  logic [7:0] slave_byte;
  logic [2:0] fall_cnt;

  assign miso_a = use_slave ? slave_byte[3'd7 - fall_cnt] : mosi_a;

  spi_controller #(.WIDTH(8), .DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_tx(data_a), .data_rx(data_rx_a),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_controller #(.WIDTH(8), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_tx(data_b), .data_rx(data_rx_b),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b)
  );

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
    int         busy;
    int         rises;
  } exp_t;
  exp_t sb[$];

  int compared = 0, mismatched = 0;
  int rises, busy_cnt, low_cnt, last_gap;
  logic [7:0] mosi_seq;
  logic sclk_prev, busy_prev, done_prev;

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        rises = 0; busy_cnt = 0; fall_cnt = '0; mosi_seq = '0;
      end else begin
        if (sclk_a && !sclk_prev) begin
          rises++;
          mosi_seq = {mosi_seq[6:0], mosi_a};
        end
        if (!sclk_a && sclk_prev) fall_cnt = fall_cnt + 3'd1;
        if (busy_a) busy_cnt++;
        if (busy_a && !busy_prev) last_gap = low_cnt;
        low_cnt = busy_a ? 0 : low_cnt + 1;
        if (done_a) begin
          chk("done_width", int'(done_prev), 0);
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("data_rx", int'(data_rx_a), int'(e.rx));
            chk("mosi_seq", int'(mosi_seq), int'(e.mosi));
            chk("busy_len", busy_cnt, e.busy);
            chk("sclk_rises", rises, e.rises);
          end
          rises = 0; busy_cnt = 0;
        end
      end
      sclk_prev = sclk_a; busy_prev = busy_a; done_prev = done_a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] d);
    data_a = d;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int bound);
    int n = 0;
    while (!done_a && n < bound) begin
      tick();
      n++;
    end
    if (!done_a) chk("done_timeout", 0, 1);
  endtask

  task automatic run();
    int bc, tog, rs, n;
    logic prev;
    reset = 1'b1; start_a = 1'b0; data_a = '0; start_b = 1'b0; data_b = '0;
    use_slave = 1'b0; slave_byte = '0;
    repeat (3) tick();
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_mosi", int'(mosi_a), 0);
    chk("rst_data_rx", int'(data_rx_a), 0);
    reset = 1'b0;
    tick();
    // loopback A5
    sb.push_back('{8'hA5, 8'hA5, 32, 8});
    pulse_a(8'hA5);
    wait_done_a(100);
    repeat (3) tick();
    // slave returns 3C while sending FF
    use_slave = 1'b1; slave_byte = 8'h3C;
    sb.push_back('{8'h3C, 8'hFF, 32, 8});
    pulse_a(8'hFF);
    wait_done_a(100);
    repeat (3) tick();
    use_slave = 1'b0;
    // start held across two transfers
    sb.push_back('{8'h01, 8'h01, 32, 8});
    sb.push_back('{8'h80, 8'h80, 32, 8});
    data_a = 8'h01; start_a = 1'b1;
    tick();
    wait_done_a(100);
    data_a = 8'h80;
    tick();
    wait_done_a(100);
    start_a = 1'b0;
    chk("busy_gap", last_gap, 1);
    repeat (3) tick();
    // reset mid-transfer
    pulse_a(8'hC3);
    repeat (9) tick();
    chk("busy_before_reset", int'(busy_a), 1);
    reset = 1'b1;
    tick();
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_sclk", int'(sclk_a), 0);
    chk("abort_mosi", int'(mosi_a), 0);
    chk("abort_data_rx", int'(data_rx_a), 0);
    chk("abort_done", int'(done_a), 0);
    reset = 1'b0;
    tick();
    sb.push_back('{8'h96, 8'h96, 32, 8});
    pulse_a(8'h96);
    wait_done_a(100);
    repeat (3) tick();
    // start and data_tx disturbed mid-transfer
    sb.push_back('{8'h4B, 8'h4B, 32, 8});
    pulse_a(8'h4B);
    repeat (12) tick();
    pulse_a(8'hFF);
    wait_done_a(100);
    data_a = '0;
    repeat (40) tick();
    // DIV=1 loopback 5A
    data_b = 8'h5A; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    bc = 0; tog = 0; rs = 0; n = 0; prev = sclk_b;
    while (!done_b && n < 100) begin
      @(negedge clk);
      if (busy_b) bc++;
      if (sclk_b != prev) tog++;
      if (sclk_b && !prev) rs++;
      prev = sclk_b;
      n++;
    end
    chk("div1_done_seen", int'(done_b), 1);
    chk("div1_busy_len", bc, 16);
    chk("div1_sclk_toggles", tog, 16);
    chk("div1_sclk_rises", rs, 8);
    chk("div1_data_rx", int'(data_rx_b), 8'h5A);
    @(negedge clk);
    chk("div1_done_width", int'(done_b), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rises = 0; busy_cnt = 0; low_cnt = 0; last_gap = 0; mosi_seq = '0; fall_cnt = '0;
    sclk_prev = 1'b0; busy_prev = 1'b0; done_prev = 1'b0;
    fork
      monitor();
      run();
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
